// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory controller.
// Holds the size encodings, the FSM state type, and the byte-enable, store and load steering.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic logic misaligned(size_e size, logic [1:0] lane);
    case (size)
      SZ_WORD: return lane != 2'b00;
      SZ_HALF: return lane[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(size_e size, logic [1:0] lane);
    case (size)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << lane;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane; byte enables pick the live one.
  function automatic logic [31:0] store_data(size_e size, logic [31:0] wdata);
    case (size)
      SZ_HALF: return {2{wdata[15:0]}};
      SZ_BYTE: return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] word, size_e size,
                                           logic [1:0] lane, logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_WORD: return word;
      SZ_HALF: return {{16{sext & h[15]}}, h};
      SZ_BYTE: return {{24{sext & b[7]}}, b};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store bus between the CPU datapath and the data-memory controller.
interface dmem_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, size, sext, addr, wdata,
                  input  rdata, ready, err);
  modport slave  (input  req, we, size, sext, addr, wdata,
                  output rdata, ready, err);
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous byte-enabled write and asynchronous read.
module dmem_array #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: captures one access, waits LATENCY cycles, then
// pulses ready with registered rdata/err; stores commit at the end of RESP.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic   clk_in,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q;
  size_e              size_q;
  logic               sext_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               capture;

  logic [1:0]         lane;
  logic [ADDR_W-1:0]  idx;
  logic               mis;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rd;
  logic               unused_addr_hi;

  // Address bits above the word index wrap and are deliberately ignored.
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  assign lane      = addr_q[1:0];
  assign idx       = addr_q[ADDR_W+1:2];
  assign mis       = misaligned(size_q, lane);
  assign mem_we    = (state_q == S_RESP) && we_q && !mis;
  assign mem_be    = byte_en(size_q, lane);
  assign mem_wdata = store_data(size_q, wdata_q);

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (clk_in),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (idx),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Output registers load on the WAIT->RESP edge so they are valid throughout RESP.
        if (cnt_q == '0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          err_d   = mis;
          rdata_d = (!we_q && !mis) ? load_ext(mem_rd, size_q, lane, sext_q) : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (capture) begin
        we_q    <= bus.we;
        size_q  <= size_e'(bus.size);
        sext_q  <= bus.sext;
        addr_q  <= bus.addr[ADDR_W+1:0];
        wdata_q <= bus.wdata;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with two instances: LATENCY=1 and LATENCY=4.
module tb_dmem_ctrl;

  logic clk;
  logic rst_n;

  dmem_if b1 ();
  dmem_if b4 ();

  dmem_ctrl #(.ADDR_W(8), .LATENCY(1)) u_dut1 (.clk_in(clk), .reset(rst_n), .bus(b1));
  dmem_ctrl #(.ADDR_W(8), .LATENCY(4)) u_dut4 (.clk_in(clk), .reset(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] err;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm1 [256];
  logic [31:0] mm4 [256];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_bus(input int d, input logic r, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
    if (d == 1) begin
      b1.req = r; b1.we = w; b1.size = sz; b1.sext = sx; b1.addr = a; b1.wdata = wd;
    end else begin
      b4.req = r; b4.we = w; b4.size = sz; b4.sext = sx; b4.addr = a; b4.wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 1) ? b1.ready : b4.ready;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 1) ? b1.rdata : b4.rdata;
  endfunction

  function automatic logic get_err(input int d);
    return (d == 1) ? b1.err : b4.err;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] w, input logic [1:0] sz,
                                        input logic sx, input logic [1:0] lo);
    logic [31:0] s;
    s = w >> (8 * lo);
    case (sz)
      2'b00:   return w;
      2'b01:   return (sx && s[15]) ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
      2'b10:   return (sx && s[7])  ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
      default: return 32'h0;
    endcase
  endfunction

  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    exp_t        e;
    logic [1:0]  lo;
    logic [7:0]  idx;
    logic [31:0] cur;
    logic [31:0] nw;
    logic        mis;
    int          n;
    lo  = a[1:0];
    idx = a[9:2];
    mis = (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b00 && lo != 2'b00);
    cur = (d == 1) ? mm1[idx] : mm4[idx];
    e.err   = {31'b0, mis};
    e.rdata = (!w && !mis) ? mload(cur, sz, sx, lo) : 32'h0;
    e.lat   = (d == 1) ? 32'd2 : 32'd5;
    if (w && !mis) begin
      nw = cur;
      case (sz)
        2'b00: nw = wd;
        2'b01: nw[lo[1]*16 +: 16] = wd[15:0];
        default: nw[lo*8 +: 8] = wd[7:0];
      endcase
      if (d == 1) mm1[idx] = nw; else mm4[idx] = nw;
    end
    sb.push_back(e);
    @(negedge clk);
    set_bus(d, 1'b1, w, sz, sx, a, wd);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: captured fields must not follow them.
    set_bus(d, 1'b0, ~w, 2'($urandom), ~sx, $urandom, $urandom);
    n = 1;
    while (!get_ready(d) && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({tag, ".lat"},   32'(n), e.lat);
    chk({tag, ".rdata"}, get_rdata(d), e.rdata);
    chk({tag, ".err"},   {31'b0, get_err(d)}, e.err);
    @(negedge clk);
    chk({tag, ".pulse"}, {31'b0, get_ready(d)}, 32'h0);
    set_bus(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic        seen;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;

    rst_n = 1'b0;
    set_bus(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_bus(4, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst.ready1", {31'b0, b1.ready}, 32'h0);
    chk("rst.err1",   {31'b0, b1.err},   32'h0);
    chk("rst.rdata1", b1.rdata,          32'h0);
    chk("rst.ready4", {31'b0, b4.ready}, 32'h0);
    chk("rst.err4",   {31'b0, b4.err},   32'h0);
    chk("rst.rdata4", b4.rdata,          32'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | b1.ready | b4.ready;
    end
    chk("idle.noready", {31'b0, seen}, 32'h0);

    // LATENCY=1: word, lanes, extension, misalignment
    access(1, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, "st.w10");
    access(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        "ld.w10");
    access(1, 1'b1, 2'b10, 1'b0, 32'h13, 32'h0000_0080, "st.b13");
    access(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        "ld.w10b");
    access(1, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0,        "ld.b13s");
    access(1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        "ld.b13z");
    access(1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        "ld.h12s");
    access(1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        "mis.ldw11");
    access(1, 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_1234, "mis.sth13");
    access(1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        "mis.rsvd");
    access(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        "ld.w10c");

    for (int i = 0; i < 8; i++)
      access(1, 1'b1, 2'b00, 1'b0, 32'h40 + 32'(i * 4), $urandom, "rnd.init");
    for (int i = 0; i < 24; i++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a  = 32'h40 + 32'($urandom_range(0, 31));
      access(1, w, sz, 1'($urandom), a, $urandom, "rnd.mix");
    end

    // LATENCY=4: latency and address wrap
    access(4, 1'b1, 2'b00, 1'b0, 32'h400, 32'h12345678, "l4.st400");
    access(4, 1'b0, 2'b00, 1'b0, 32'h000, 32'h0,        "l4.ld000");
    access(4, 1'b1, 2'b00, 1'b0, 32'h20,  32'h0,        "l4.st20z");

    // Reset in the middle of a pending store's wait
    @(negedge clk);
    set_bus(4, 1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'hA5A5_A5A5);
    @(posedge clk);
    @(negedge clk);
    set_bus(4, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | b4.ready | b4.err;
    end
    chk("mid.rdata", b4.rdata, 32'h0);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen = seen | b4.ready | b4.err;
    end
    chk("mid.noready", {31'b0, seen}, 32'h0);
    access(4, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, "mid.ld20");
    access(4, 1'b0, 2'b01, 1'b0, 32'h402, 32'h0, "l4.ldh402");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
